// File: rtl/piano_tone_gen.sv
// Piano tone generator: lowest pressed key picks a note, square wave out.
// Define PIANO_TONE_SYNC_EN to pass keys through a 2-flop synchronizer.
module piano_tone_gen #(
  parameter int HP0         = 95556,
  parameter int HP1         = 85131,
  parameter int HP2         = 75843,
  parameter int HP3         = 71586,
  parameter int HP4         = 63776,
  parameter int HP5         = 56818,
  parameter int HP6         = 50619,
  parameter int RELEASE_CYC = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] keys,
  output logic       tone_out,
  output logic [2:0] note_idx,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_REL  = 2'd2
  } state_t;

  localparam logic [2:0]  NOTE_NONE = 3'd7;
  localparam logic [16:0] HPM0 = 17'(HP0 - 1);
  localparam logic [16:0] HPM1 = 17'(HP1 - 1);
  localparam logic [16:0] HPM2 = 17'(HP2 - 1);
  localparam logic [16:0] HPM3 = 17'(HP3 - 1);
  localparam logic [16:0] HPM4 = 17'(HP4 - 1);
  localparam logic [16:0] HPM5 = 17'(HP5 - 1);
  localparam logic [16:0] HPM6 = 17'(HP6 - 1);
  localparam logic [21:0] REL_LAST =
    22'(RELEASE_CYC - 1);

  state_t      state;
  state_t      state_n;
  logic [6:0]  keys_s;
  logic        any_key;
  logic [2:0]  sel;
  logic [16:0] hp_last;
  logic        wrap;
  logic [16:0] cnt;
  logic [16:0] cnt_n;
  logic [16:0] cnt_adv;
  logic [21:0] rel;
  logic [21:0] rel_n;
  logic        tone_n;
  logic        tone_adv;
  logic [2:0]  note_n;

`ifdef PIANO_TONE_SYNC_EN
  logic [6:0] sync1;
  logic [6:0] sync2;

  // two-flop synchronizer for the asynchronous key vector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  assign keys_s = sync2;
`else
  assign keys_s = keys;
`endif

  assign any_key = |keys_s;

  // lowest-numbered pressed key wins
  always_comb begin
    sel = NOTE_NONE;
    priority case (1'b1)
      keys_s[0]: sel = 3'd0;
      keys_s[1]: sel = 3'd1;
      keys_s[2]: sel = 3'd2;
      keys_s[3]: sel = 3'd3;
      keys_s[4]: sel = 3'd4;
      keys_s[5]: sel = 3'd5;
      keys_s[6]: sel = 3'd6;
      default:   sel = NOTE_NONE;
    endcase
  end

  // last count value of the half-period for the sounding note
  always_comb begin
    hp_last = HPM0;
    case (note_idx)
      3'd0:    hp_last = HPM0;
      3'd1:    hp_last = HPM1;
      3'd2:    hp_last = HPM2;
      3'd3:    hp_last = HPM3;
      3'd4:    hp_last = HPM4;
      3'd5:    hp_last = HPM5;
      3'd6:    hp_last = HPM6;
      default: hp_last = HPM0;
    endcase
  end

  assign wrap     = (cnt == hp_last);
  assign cnt_adv  = wrap ? '0 : cnt + 17'd1;
  assign tone_adv = wrap ? ~tone_out : tone_out;

  // next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rel_n   = rel;
    tone_n  = tone_out;
    note_n  = note_idx;
    unique case (state)
      S_IDLE: begin
        tone_n = 1'b0;
        note_n = NOTE_NONE;
        cnt_n  = '0;
        rel_n  = '0;
        if (any_key) begin
          state_n = S_PLAY;
          note_n  = sel;
          tone_n  = 1'b1;
        end
      end
      S_PLAY: begin
        if (!any_key) begin
          state_n = S_REL;
          rel_n   = '0;
          cnt_n   = cnt_adv;
          tone_n  = tone_adv;
        end else if (sel != note_idx) begin
          note_n = sel;
          cnt_n  = '0;
          tone_n = 1'b1;
        end else begin
          cnt_n  = cnt_adv;
          tone_n = tone_adv;
        end
      end
      S_REL: begin
        if (any_key) begin
          state_n = S_PLAY;
          if (sel != note_idx) begin
            note_n = sel;
            cnt_n  = '0;
            tone_n = 1'b1;
          end else begin
            cnt_n  = cnt_adv;
            tone_n = tone_adv;
          end
        end else if (rel == REL_LAST) begin
          state_n = S_IDLE;
          tone_n  = 1'b0;
          note_n  = NOTE_NONE;
          cnt_n   = '0;
          rel_n   = '0;
        end else begin
          rel_n  = rel + 22'd1;
          cnt_n  = cnt_adv;
          tone_n = tone_adv;
        end
      end
      default: begin
        state_n = S_IDLE;
        tone_n  = 1'b0;
        note_n  = NOTE_NONE;
        cnt_n   = '0;
        rel_n   = '0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rel      <= '0;
      tone_out <= 1'b0;
      note_idx <= NOTE_NONE;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rel      <= rel_n;
      tone_out <= tone_n;
      note_idx <= note_n;
      busy     <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_piano_tone_gen.sv
// Bench for piano_tone_gen with small half-periods.
// Expected output per cycle is queued and popped after each edge.
module tb_piano_tone_gen;

`ifdef PIANO_TONE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic       tone;
    logic [2:0] note;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [6:0] keys;
  logic       tone_out;
  logic [2:0] note_idx;
  logic       busy;

  int   tests;
  int   fails;
  exp_t sb[$];

  piano_tone_gen #(
    .HP0(4),
    .HP1(3),
    .HP6(2),
    .RELEASE_CYC(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keys(keys),
    .tone_out(tone_out),
    .note_idx(note_idx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    keys = 7'h00;
    repeat (LAT + 12) tick();
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e.tone = 1'b0;
    e.note = 3'd7;
    e.busy = 1'b0;
    return e;
  endfunction

  function automatic exp_t play_e(int k, int hp, int n);
    exp_t e;
    e.tone = ((k / hp) % 2) == 0;
    e.note = 3'(n);
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    exp_t g;
    reset = 1'b1;
    keys  = 7'h00;
    tick();
    tick();
    tests++;
    if (tone_out !== 1'b0 || note_idx !== 3'd7 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_init got %b/%0d/%b want 0/7/0",
               tone_out, note_idx, busy);
    end
    reset = 1'b0;
    keys  = 7'h01;
    for (int c = 1; c <= 20; c++) begin
      sb.push_back(c < LAT ? idle_e() :
                   play_e(c - LAT, 4, 0));
      tick();
      e = sb.pop_front();
      g = '{tone_out, note_idx, busy};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL pre_reset c=%0d got %b want %b",
                 c, g, e);
      end
    end
    reset = 1'b1;
    #1;
    tests++;
    if (tone_out !== 1'b0 || note_idx !== 3'd7 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got %b/%0d/%b want 0/7/0",
               tone_out, note_idx, busy);
    end
    keys = 7'h00;
    #3;
    reset = 1'b0;
    repeat (4) tick();
    tests++;
    if (tone_out !== 1'b0 || note_idx !== 3'd7 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_after got %b/%0d/%b want 0/7/0",
               tone_out, note_idx, busy);
    end
  endtask

  task automatic test_tone(input int key, input int hp);
    exp_t e;
    exp_t g;
    keys = 7'h00;
    keys[key] = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      sb.push_back(c < LAT ? idle_e() :
                   play_e(c - LAT, hp, key));
      tick();
      e = sb.pop_front();
      g = '{tone_out, note_idx, busy};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL tone_k%0d c=%0d got %b want %b",
                 key, c, g, e);
      end
    end
    settle();
    tests++;
    if (busy !== 1'b0 || note_idx !== 3'd7) begin
      fails++;
      $display("FAIL tone_idle busy=%b note=%0d want 0/7",
               busy, note_idx);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    exp_t g;
    keys = 7'h41;
    for (int c = 1; c <= 26; c++) begin
      if (c == 11) keys = 7'h40;
      if (c < LAT)
        sb.push_back(idle_e());
      else if (c < 10 + LAT)
        sb.push_back(play_e(c - LAT, 4, 0));
      else
        sb.push_back(play_e(c - 10 - LAT, 2, 6));
      tick();
      e = sb.pop_front();
      g = '{tone_out, note_idx, busy};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL priority c=%0d got %b want %b",
                 c, g, e);
      end
    end
    settle();
  endtask

  task automatic test_release();
    exp_t e;
    exp_t g;
    int   p;
    p = 12;
    keys = 7'h01;
    for (int c = 1; c <= p + LAT + 12; c++) begin
      if (c == p + 1) keys = 7'h00;
      if (c < LAT || c >= p + LAT + 8)
        sb.push_back(idle_e());
      else
        sb.push_back(play_e(c - LAT, 4, 0));
      tick();
      e = sb.pop_front();
      g = '{tone_out, note_idx, busy};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL release c=%0d got %b want %b",
                 c, g, e);
      end
    end
    settle();
  endtask

  task automatic test_repress(input int gap,
                              input int key_new,
                              input int hp_new);
    exp_t e;
    exp_t g;
    int   p;
    int   t;
    p = 12;
    t = p + gap + LAT;
    keys = 7'h01;
    for (int c = 1; c <= t + 16; c++) begin
      if (c == p + 1) keys = 7'h00;
      if (c == p + 1 + gap) begin
        keys = 7'h00;
        keys[key_new] = 1'b1;
      end
      if (c < LAT)
        sb.push_back(idle_e());
      else if (c < t || key_new == 0)
        sb.push_back(play_e(c - LAT, 4, 0));
      else
        sb.push_back(play_e(c - t, hp_new, key_new));
      tick();
      e = sb.pop_front();
      g = '{tone_out, note_idx, busy};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL repress g%0d k%0d c=%0d got %b want %b",
                 gap, key_new, c, g, e);
      end
    end
    settle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    keys  = 7'h00;
    test_reset();
    test_tone(0, 4);
    test_tone(1, 3);
    test_tone(6, 2);
    test_priority();
    test_release();
    test_repress(6, 0, 4);
    test_repress(8, 0, 4);
    test_repress(3, 6, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piano_tone_gen.md
PIANO_TONE_GEN -- requirements
Module: piano_tone_gen

Interface
REQ-001 SHALL have parameter HP0..HP6, defaults 95556, 85131, 75843, 71586, 63776, 56818, 50619: half-period in clk cycles for keys 0..6 (C4..B4 at 50 MHz); legal range 2..131071.
REQ-002 SHALL have parameter RELEASE_CYC, default 2500000: tone hold time after all keys release; legal range 1..4194303.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 keys  input  7  piano key vector from the LED/key PIO out_port; bit i = key i pressed.
REQ-006 tone_out  output  1  registered square wave to buzzer/audio pin.
REQ-007 note_idx  output  3  registered index of sounding note; 7 = none.
REQ-008 busy  output  1  registered; high when state is not IDLE.

Function
REQ-009 keys_s SHALL be the sampled key vector (see Configuration); all decisions use keys_s only.
REQ-010 Priority: lowest-numbered set bit of keys_s SHALL select the note; the selected note's half-period is HP[note].
REQ-011 FSM states SHALL be IDLE, PLAY, RELEASE; 17-bit period counter cnt, 22-bit release counter rel.
REQ-012 IDLE: tone_out=0, note_idx=7, cnt=0; if keys_s!=0 -> PLAY next cycle with note latched, cnt=0, tone_out=1.
REQ-013 PLAY, keys_s==0: -> RELEASE, rel=0, tone continues toggling unchanged.
REQ-014 PLAY, selected note differs from note_idx: note_idx<=new, cnt<=0, tone_out<=1 (phase restart), same cycle.
REQ-015 PLAY, same note: if cnt==HP[note_idx]-1 then cnt<=0 and tone_out toggles, else cnt increments; tone period = 2*HP cycles exactly.
REQ-016 RELEASE: tone keeps toggling per REQ-015; rel increments each cycle.
REQ-017 RELEASE, keys_s!=0: -> PLAY; same note continues without phase restart, different note handled per REQ-014; keys_s check has priority over release expiry.
REQ-018 RELEASE, rel==RELEASE_CYC-1 and keys_s==0: -> IDLE, tone_out<=0, note_idx<=7, cnt<=0.
REQ-019 Multiple simultaneous keys SHALL never produce a blend; only the REQ-010 winner sounds.
REQ-020 busy SHALL be 1 in PLAY and RELEASE, 0 in IDLE, updated with the state register.

Reset
REQ-021 Asserting reset SHALL immediately force state=IDLE, tone_out=0, note_idx=7, busy=0, cnt=0, rel=0, synchronizer flops=0, regardless of state mid-tone.
REQ-022 After reset deasserts, the first key detection follows REQ-012 with no extra cycles beyond the Configuration latency.

Configuration
REQ-023 Macro PIANO_TONE_SYNC_EN defined: keys SHALL pass through a 2-flop synchronizer; keys-to-tone_out-rise latency = 3 clk cycles.
REQ-024 Macro PIANO_TONE_SYNC_EN undefined: keys_s=keys directly; keys-to-tone_out-rise latency = 1 clk cycle.

Verification (HP0=4, HP1=3, HP6=2, RELEASE_CYC=8, sync disabled unless stated)
REQ-025 Reset mid-tone: keys=7'h01 for 20 cycles, pulse reset -> same cycle tone_out=0, note_idx=7, busy=0.
REQ-026 keys=7'h01 held -> tone_out rises 1 cycle later, then toggles every 4 cycles (period 8), note_idx=0, busy=1.
REQ-027 keys=7'h41 -> note_idx=0 (key 0 wins); then keys=7'h40 -> next cycle note_idx=6, tone_out=1, period 4.
REQ-028 keys 7'h01 -> 7'h00 -> tone continues 8 cycles, then tone_out=0, note_idx=7, busy=0; keys=7'h01 at release cycle 5 -> back to PLAY, no phase restart.
REQ-029 PIANO_TONE_SYNC_EN defined, keys=7'h02 -> tone_out rises 3 cycles later, period 6, note_idx=1.
